// File: rtl/cam_rx_pages.sv
// Paged receive buffer: packs camera stream bytes into fixed-size RAM pages,
// tags each with a flag word at commit, and hands committed pages to cam_csr in order.
module cam_rx_pages #(
  parameter int unsigned PAGE_AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic [7:0]  pkt_size,
  input  logic [7:0]  rx_ram_rd_addr,
  input  logic        rx_ram_rd_done,
  input  logic        rx_clean_all,
  output logic [7:0]  rx_ram_rd_byte,
  output logic [15:0] rx_ram_rd_flags,
  output logic        rx_ram_lost,
  output logic        rx_pending
);

  localparam int unsigned PAGE_NUM = 2 ** PAGE_AW;
  localparam int unsigned CNT_W    = PAGE_AW + 1;
  localparam int unsigned ADDR_W   = PAGE_AW + 8;
  localparam int unsigned SEQ_W    = 5;

  typedef enum logic [1:0] {WAIT_SOF, FILL, DROP} state_e;

  state_e               state_q, state_d;
  logic [PAGE_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PAGE_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [7:0]           idx_q, idx_d;
  logic [7:0]           psz_q, psz_d;
  logic                 sof_q, sof_d;
  logic                 lost_sticky_q, lost_sticky_d;
  logic                 lost_q, lost_d;
  logic                 pending_q, pending_d;
  logic [7:0]           rd_byte_q;
  logic [15:0]          rd_flags_q;

  logic [7:0]           mem [PAGE_NUM*256];
  logic [15:0]          flags_mem [PAGE_NUM];

  logic                 full;
  logic                 take_byte;
  logic                 commit;
  logic                 rd_do;
  logic                 mem_we;
  logic                 flag_we;
  logic [7:0]           psz_eff;
  logic [15:0]          flag_wdata;
  logic [ADDR_W-1:0]    mem_waddr;

  // Writer FSM, page queue bookkeeping and clean/resync priority
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    seq_d         = seq_q;
    idx_d         = idx_q;
    psz_d         = psz_q;
    sof_d         = sof_q;
    lost_sticky_d = lost_sticky_q;
    lost_d        = 1'b0;
    take_byte     = 1'b0;
    commit        = 1'b0;
    mem_we        = 1'b0;
    flag_we       = 1'b0;
    flag_wdata    = '0;
    mem_waddr     = {wr_ptr_q, idx_q};
    full          = (count_q == CNT_W'(PAGE_NUM));
    psz_eff       = (idx_q == 8'd0) ? pkt_size : psz_q;
    rd_do         = rx_ram_rd_done && (count_q != '0);

    if (pix_valid) begin
      if (frame_start) seq_d = seq_q + SEQ_W'(1);
      case (state_q)
        WAIT_SOF: take_byte = frame_start;
        FILL: begin
          if ((idx_q == 8'd0) && full) begin
            lost_d        = 1'b1;
            lost_sticky_d = 1'b1;
            state_d       = DROP;
          end else begin
            take_byte = 1'b1;
          end
        end
        DROP:     take_byte = !full;
        default:  take_byte = 1'b0;
      endcase
    end

    if (take_byte) begin
      state_d = FILL;
      mem_we  = 1'b1;
      if (idx_q == 8'd0) psz_d = pkt_size;
      sof_d = (idx_q == 8'd0) ? frame_start : (sof_q | frame_start);
      if ((idx_q == psz_eff) || frame_end) begin
        commit        = 1'b1;
        flag_we       = 1'b1;
        flag_wdata    = {seq_d, lost_sticky_q, frame_end, sof_d, idx_q};
        lost_sticky_d = 1'b0;
        idx_d         = 8'd0;
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end

    if (commit) wr_ptr_d = wr_ptr_q + PAGE_AW'(1);
    if (rd_do)  rd_ptr_d = rd_ptr_q + PAGE_AW'(1);
    case ({commit, rd_do})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Clean-all drops everything, including any commit or free in this cycle
    if (rx_clean_all) begin
      mem_we        = 1'b0;
      flag_we       = 1'b0;
      lost_d        = 1'b0;
      seq_d         = seq_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = wr_ptr_q;
      count_d       = '0;
      idx_d         = 8'd0;
      lost_sticky_d = 1'b0;
      state_d       = WAIT_SOF;
    end

    pending_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_SOF;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      seq_q         <= '0;
      idx_q         <= '0;
      psz_q         <= '0;
      sof_q         <= 1'b0;
      lost_sticky_q <= 1'b0;
      lost_q        <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      seq_q         <= seq_d;
      idx_q         <= idx_d;
      psz_q         <= psz_d;
      sof_q         <= sof_d;
      lost_sticky_q <= lost_sticky_d;
      lost_q        <= lost_d;
      pending_q     <= pending_d;
    end
  end

  // Page and flag storage, kept reset-free so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we)  mem[mem_waddr]      <= pix_data;
    if (flag_we) flags_mem[wr_ptr_q] <= flag_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_byte_q  <= '0;
      rd_flags_q <= '0;
    end else begin
      rd_byte_q  <= mem[{rd_ptr_q, rx_ram_rd_addr}];
      rd_flags_q <= flags_mem[rd_ptr_q];
    end
  end

  assign rx_ram_rd_byte  = rd_byte_q;
  assign rx_ram_rd_flags = rd_flags_q;
  assign rx_ram_lost     = lost_q;
  assign rx_pending      = pending_q;

endmodule
